// File: rtl/lcd_resp_pkg.sv
// Shared types and constants for the HD44780 bus responder: FSM states,
// opcode masks, the blank character and DDRAM line bases.
package lcd_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CLR  = 2'd2,
        ST_BUSY = 2'd3
    } state_e;

    localparam logic [7:0] BLANK      = 8'h20;
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h60;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } ddram_map_t;

    // Each visible line is 16 cells, so only the upper three address bits
    // select the line; the low nibble is the column.
    function automatic ddram_map_t map_ddram(input logic [6:0] addr);
        ddram_map_t m;
        m.valid = 1'b0;
        m.idx   = 5'd0;
        if (addr[6:4] == LINE0_BASE[6:4]) begin
            m.valid = 1'b1;
            m.idx   = {1'b0, addr[3:0]};
        end else if (addr[6:4] == LINE1_BASE[6:4]) begin
            m.valid = 1'b1;
            m.idx   = {1'b1, addr[3:0]};
        end
        return m;
    endfunction

    function automatic logic [4:0] cursor_step(input logic [4:0] c, input logic up);
        return up ? c + 5'd1 : c - 5'd1;
    endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// Busy countdown: load a cycle count, decrement while counting, and flag
// the final counting cycle so the FSM can leave BUSY after exactly N cycles.
module lcd_busy_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         count,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero load still terminates instead of stalling in BUSY.
    assign done = count && (cnt_q <= W'(1));

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Behavioural HD44780 bus responder holding a 32-cell character buffer.
// Define LCD_RESP_READ_EN to enable busy-flag and data read-back.
module lcd_hd44780_responder
    import lcd_resp_pkg::*;
#(
    parameter int BUSY_CYC  = 40,
    parameter int CLEAR_CYC = 1640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic       lcd_on,
    output logic [7:0] lcd_dout,
    output logic       lcd_dout_oe,
    output logic       busy,
    output logic [4:0] cursor,
    output logic       disp_on,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       cmd_err
);

    localparam int CW = $clog2(CLEAR_CYC + 1);
    localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYC);
    localparam logic [CW-1:0] CLR_LD  = CW'(CLEAR_CYC);

    state_e     state_q, state_d;
    logic [4:0] cursor_q, cursor_d;
    logic       inc_q, inc_d;
    logic       disp_q, disp_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic       en_q, en_d;
    logic [7:0] data_s_q, data_s_d;
    logic       rs_s_q, rs_s_d;
    logic       rw_s_q, rw_s_d;
    logic [7:0] mem_q [32];

    logic          xfer;
    logic          buf_we;
    logic [4:0]    buf_wa;
    logic [7:0]    buf_wd;
    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic          tmr_done;
    ddram_map_t    dm;

    lcd_busy_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .count    (state_q == ST_BUSY),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    assign xfer = en_q & ~lcd_en & lcd_on;

    always_comb begin
        en_d     = lcd_en;
        data_s_d = lcd_en ? lcd_data : data_s_q;
        rs_s_d   = lcd_en ? lcd_rs : rs_s_q;
        rw_s_d   = lcd_en ? lcd_rw : rw_s_q;

        state_d      = state_q;
        cursor_d     = cursor_q;
        inc_d        = inc_q;
        disp_d       = disp_q;
        err_d        = err_q;
        clr_idx_d    = clr_idx_q;
        tmr_load     = 1'b0;
        tmr_load_val = BUSY_LD;
        buf_we       = 1'b0;
        buf_wa       = cursor_q;
        buf_wd       = data_s_q;
        dm           = map_ddram(data_s_q[6:0]);

        // Busy-flag polls are the one transfer the bus may legally make mid-execution.
        if (xfer && state_q != ST_IDLE) begin
`ifdef LCD_RESP_READ_EN
            if (!(rw_s_q && !rs_s_q)) err_d = 1'b1;
`else
            err_d = 1'b1;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (rw_s_q) begin
`ifdef LCD_RESP_READ_EN
                        if (rs_s_q) cursor_d = cursor_step(cursor_q, inc_q);
`else
                        err_d = 1'b1;
`endif
                    end else if (!rs_s_q && data_s_q == OP_CLEAR) begin
                        state_d   = ST_CLR;
                        cursor_d  = 5'd0;
                        inc_d     = 1'b1;
                        clr_idx_d = 5'd0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d  = ST_BUSY;
                tmr_load = 1'b1;
                if (rs_s_q) begin
                    buf_we   = 1'b1;
                    cursor_d = cursor_step(cursor_q, inc_q);
                end else if (|(data_s_q & OP_DDRAM)) begin
                    if (dm.valid) cursor_d = dm.idx;
                    else          err_d    = 1'b1;
                end else if (|(data_s_q & OP_FUNC)) begin
                    state_d = ST_BUSY;
                end else if (|(data_s_q & OP_SHIFT)) begin
                    if (!data_s_q[3]) cursor_d = cursor_step(cursor_q, data_s_q[2]);
                end else if (|(data_s_q & OP_DISPLAY)) begin
                    disp_d = data_s_q[2];
                end else if (|(data_s_q & OP_ENTRY)) begin
                    inc_d = data_s_q[1];
                end else if (|(data_s_q & OP_HOME)) begin
                    cursor_d     = 5'd0;
                    tmr_load_val = CLR_LD;
                end
            end
            ST_CLR: begin
                buf_we    = 1'b1;
                buf_wa    = clr_idx_q;
                buf_wd    = BLANK;
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    state_d      = ST_BUSY;
                    tmr_load     = 1'b1;
                    tmr_load_val = CLR_LD;
                end
            end
            ST_BUSY: begin
                if (tmr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cursor_q  <= 5'd0;
            inc_q     <= 1'b1;
            disp_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            clr_idx_q <= 5'd0;
            en_q      <= 1'b0;
            data_s_q  <= 8'h00;
            rs_s_q    <= 1'b0;
            rw_s_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            inc_q     <= inc_d;
            disp_q    <= disp_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            clr_idx_q <= clr_idx_d;
            en_q      <= en_d;
            data_s_q  <= data_s_d;
            rs_s_q    <= rs_s_d;
            rw_s_q    <= rw_s_d;
        end
    end

    // Buffer is deliberately not reset; a reset only blocks the pending write.
    always_ff @(posedge clk) begin
        if (rst && buf_we) begin
            mem_q[buf_wa] <= buf_wd;
        end
    end

`ifdef LCD_RESP_READ_EN
    logic [7:0] dout_q, dout_d;
    logic       oe_q, oe_d;

    always_comb begin
        dout_d = 8'h00;
        oe_d   = 1'b0;
        if (lcd_rw && lcd_en) begin
            oe_d   = 1'b1;
            dout_d = lcd_rs ? mem_q[cursor_q] : {busy_q, 2'b00, cursor_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q <= 8'h00;
            oe_q   <= 1'b0;
        end else begin
            dout_q <= dout_d;
            oe_q   <= oe_d;
        end
    end

    assign lcd_dout    = dout_q;
    assign lcd_dout_oe = oe_q;
`else
    assign lcd_dout    = 8'h00;
    assign lcd_dout_oe = 1'b0;
`endif

    assign busy    = busy_q;
    assign cursor  = cursor_q;
    assign disp_on = disp_q;
    assign cmd_err = err_q;
    assign rd_char = mem_q[rd_addr];

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed + random bench for lcd_hd44780_responder against a buffer/cursor
// reference model; read-back steps follow LCD_RESP_READ_EN.
module tb_lcd_hd44780_responder;

    localparam int BUSY_N  = 10;
    localparam int CLEAR_N = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_en = 1'b0;
    logic       lcd_on = 1'b1;
    logic [7:0] lcd_dout;
    logic       lcd_dout_oe;
    logic       busy;
    logic [4:0] cursor;
    logic       disp_on;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic       cmd_err;

    always #5 clk = ~clk;

    lcd_hd44780_responder #(.BUSY_CYC(BUSY_N), .CLEAR_CYC(CLEAR_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_data    (lcd_data),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en),
        .lcd_on      (lcd_on),
        .lcd_dout    (lcd_dout),
        .lcd_dout_oe (lcd_dout_oe),
        .busy        (busy),
        .cursor      (cursor),
        .disp_on     (disp_on),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .cmd_err     (cmd_err)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] m_mem [32];
    int         m_cur;
    logic       m_inc;
    logic       m_disp;
    logic       m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur  = 0;
        m_inc  = 1'b1;
        m_disp = 1'b0;
        m_err  = 1'b0;
    endtask

    function automatic int busy_len(input logic rs, input logic [7:0] d);
        if (!rs && d == 8'h01) return 32 + CLEAR_N;
        if (!rs && (d == 8'h02 || d == 8'h03)) return 1 + CLEAR_N;
        return 1 + BUSY_N;
    endfunction

    task automatic model_apply(input logic rs, input logic [7:0] d);
        int a;
        if (rs) begin
            m_mem[m_cur] = d;
            m_cur = (m_cur + (m_inc ? 1 : 31)) % 32;
        end else if (d == 8'h01) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_cur = 0;
            m_inc = 1'b1;
        end else if (d >= 8'h80) begin
            a = int'(d) - 128;
            if (a < 16) m_cur = a;
            else if (a >= 64 && a < 80) m_cur = a - 64 + 16;
            else m_err = 1'b1;
        end else if (d >= 8'h20) begin
            m_cur = m_cur;
        end else if (d >= 8'h10) begin
            if (!d[3]) m_cur = (m_cur + (d[2] ? 1 : 31)) % 32;
        end else if (d >= 8'h08) begin
            m_disp = d[2];
        end else if (d >= 8'h04) begin
            m_inc = d[1];
        end else if (d >= 8'h02) begin
            m_cur = 0;
        end
    endtask

    // Returns just after the clock edge on which the falling lcd_en is seen.
    task automatic send(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_en   = 1'b1;
        @(negedge clk);
        lcd_en = 1'b0;
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic exec(input logic rs, input logic [7:0] d);
        int n = 0;
        send(rs, 1'b0, d);
        @(negedge clk);
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, busy_len(rs, d));
        model_apply(rs, d);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cursor"}, {27'd0, cursor}, m_cur);
        chk({tag, "_disp"}, {31'd0, disp_on}, {31'd0, m_disp});
        chk({tag, "_err"}, {31'd0, cmd_err}, {31'd0, m_err});
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_addr = 5'(i);
            #1;
            chk($sformatf("%s_mem%0d", tag, i), {24'd0, rd_char}, {24'd0, m_mem[i]});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] d;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'hxx;

        // Reset values
        do_reset();
        check_state("reset");
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_dout", {24'd0, lcd_dout}, 32'd0);
        chk("reset_oe", {31'd0, lcd_dout_oe}, 32'd0);

        // Power-on init sequence
        exec(1'b0, 8'h38);
        exec(1'b0, 8'h0C);
        exec(1'b0, 8'h01);
        exec(1'b0, 8'h06);
        exec(1'b0, 8'h80);
        check_state("init");
        chk("init_disp_on", {31'd0, disp_on}, 32'd1);
        check_mem("init");

        // First line fill then second-line address
        exec(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) exec(1'b1, 8'h41 + 8'(i));
        chk("line0_cursor", {27'd0, cursor}, 32'd16);
        exec(1'b0, 8'hC0);
        exec(1'b1, 8'h5A);
        chk("line1_cursor", {27'd0, cursor}, 32'd17);
        check_mem("lines");

        // Decrement mode wraps below zero
        exec(1'b0, 8'h04);
        exec(1'b0, 8'h80);
        exec(1'b1, 8'h31);
        chk("wrap_cursor", {27'd0, cursor}, 32'd31);
        check_state("wrap");

        // Randomized traffic, only valid DDRAM addresses
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 5) begin
                exec(1'b1, 8'($urandom_range(0, 255)));
            end else if ($urandom_range(0, 3) == 0) begin
                d = 8'h80 | ($urandom_range(0, 1) ? 8'h40 : 8'h00) | 8'($urandom_range(0, 15));
                exec(1'b0, d);
            end else begin
                exec(1'b0, 8'($urandom_range(0, 127)));
            end
        end
        check_state("rand");
        check_mem("rand");

        // Busy-flag read issued during BUSY
        send(1'b0, 1'b0, 8'h85);
        repeat (3) @(negedge clk);
        lcd_rw = 1'b1;
        lcd_rs = 1'b0;
        lcd_en = 1'b1;
        @(negedge clk);
`ifdef LCD_RESP_READ_EN
        chk("bf_dout", {24'd0, lcd_dout}, 32'h85);
        chk("bf_oe", {31'd0, lcd_dout_oe}, 32'd1);
`else
        chk("bf_dout", {24'd0, lcd_dout}, 32'h00);
        chk("bf_oe", {31'd0, lcd_dout_oe}, 32'd0);
        m_err = 1'b1;
`endif
        lcd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lcd_rw = 1'b0;
        wait_idle();
        model_apply(1'b0, 8'h85);
        check_state("bf");

`ifdef LCD_RESP_READ_EN
        // Data read returns buffer[cursor] and advances the cursor
        @(negedge clk);
        lcd_rw = 1'b1;
        lcd_rs = 1'b1;
        lcd_en = 1'b1;
        @(negedge clk);
        chk("rd_dout", {24'd0, lcd_dout}, {24'd0, m_mem[m_cur]});
        chk("rd_oe", {31'd0, lcd_dout_oe}, 32'd1);
        lcd_en = 1'b0;
        @(negedge clk);
        lcd_rw = 1'b0;
        m_cur = (m_cur + (m_inc ? 1 : 31)) % 32;
        chk("rd_busy", {31'd0, busy}, 32'd0);
        check_state("rd");
`endif

        // Write during busy is dropped; bad DDRAM address flags an error
        do_reset();
        check_state("err_reset");
        send(1'b0, 1'b0, 8'h8F);
        send(1'b1, 1'b0, 8'h58);
        wait_idle();
        model_apply(1'b0, 8'h8F);
        m_err = 1'b1;
        check_state("overrun");
        exec(1'b0, 8'h90);
        chk("bad_addr_cursor", {27'd0, cursor}, 32'd15);
        check_state("bad_addr");
        check_mem("err");

        // Reset during CLR cycle 10
        send(1'b0, 1'b0, 8'h01);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midclr_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) m_mem[i] = 8'h20;
        model_reset();
        check_state("midclr");
        check_mem("midclr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_responder.md
LCD_HD44780_RESPONDER -- requirements
Module: lcd_hd44780_responder

Interface
REQ-001 SHALL have parameter BUSY_CYC, default 40, meaning busy cycles after any ordinary instruction or data write.
REQ-002 SHALL have parameter CLEAR_CYC, default 1640, meaning busy cycles after a clear or home instruction.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port lcd_data, input, 8 bits: LCD bus data.
REQ-006 SHALL have ports lcd_rs, lcd_rw, lcd_en, lcd_on, each input, 1 bit: LCD bus controls.
REQ-007 SHALL have port lcd_dout, output, 8 bits: read-back data.
REQ-008 SHALL have port lcd_dout_oe, output, 1 bit: read-back drive enable.
REQ-009 SHALL have port busy, output, 1 bit: responder executing.
REQ-010 SHALL have port cursor, output, 5 bits: current DDRAM address counter.
REQ-011 SHALL have port disp_on, output, 1 bit: display-on flag.
REQ-012 SHALL have port rd_addr, input, 5 bits: checker buffer index.
REQ-013 SHALL have port rd_char, output, 8 bits: buffer[rd_addr], combinational.
REQ-014 SHALL have port cmd_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-015 SHALL register lcd_en each clk and detect a transfer on a falling edge (previous 1, current 0), only while lcd_on=1.
REQ-016 SHALL use lcd_data/lcd_rs/lcd_rw as sampled on the last cycle lcd_en was high.
REQ-017 SHALL implement FSM IDLE -> EXEC (1 cycle; CLR for clear) -> BUSY -> IDLE; busy=1 in every state except IDLE.
REQ-018 SHALL, in CLR, write 8'h20 to one buffer entry per cycle, index 0..31 (32 cycles), then enter BUSY.
REQ-019 SHALL keep busy high for exactly BUSY_CYC cycles in BUSY (CLEAR_CYC after clear/home), counter width $clog2(CLEAR_CYC+1).
REQ-020 SHALL decode RS=0, RW=0 instructions by highest set bit:
  - 8'h01 clear: CLR, cursor=0, increment mode=1.
  - 8'h02-03 home: cursor=0.
  - 8'h04-07 entry: increment mode = bit1.
  - 8'h08-0F display: disp_on = bit2.
  - 8'h10-1F shift: if bit3=0, move cursor +1 if bit2=1, else -1.
  - 8'h20-7F function set / CGRAM: no state change, normal busy.
  - 8'h80+: DDRAM address.
REQ-021 SHALL map DDRAM address 0x00-0x0F to cursor 0-15 and 0x40-0x4F to cursor 16-31; any other address SHALL set cmd_err and leave cursor unchanged.
REQ-022 SHALL, for RS=1 RW=0, write lcd_data to buffer[cursor], then increment or decrement cursor per increment mode.
REQ-023 SHALL wrap cursor modulo 32 in both directions (31+1 -> 0, 0-1 -> 31).
REQ-024 SHALL ignore a transfer arriving while busy=1 and set cmd_err; cmd_err clears only on reset.
REQ-025 SHALL treat a transfer coincident with the last BUSY cycle as arriving while busy.

Reset
REQ-026 SHALL, on rst=0 at a clk edge, set:
  - state IDLE, cursor 0, increment mode 1, disp_on 0, cmd_err 0;
  - busy counter 0, edge register 0, lcd_dout 0, lcd_dout_oe 0.
REQ-027 SHALL abort any EXEC/CLR/BUSY on mid-operation reset; buffer contents are not reset (entries already blanked stay blanked).

Configuration
REQ-028 SHALL, with LCD_RESP_READ_EN defined, drive a read while lcd_rw=1 and lcd_en=1 (registered, 1-cycle latency):
  - RS=0: lcd_dout_oe=1, lcd_dout={busy, 2'b0, cursor}.
  - RS=1: lcd_dout_oe=1, lcd_dout=buffer[cursor]; cursor then advances on the falling edge per increment mode.
  - RW=1 falling edges never start EXEC and never raise busy.
REQ-029 SHALL, without LCD_RESP_READ_EN:
  - tie lcd_dout=0 and lcd_dout_oe=0;
  - treat any RW=1 transfer as ignored and set cmd_err.

Structure
REQ-030 SHALL place the FSM state enum, opcode mask constants, BLANK=8'h20, and DDRAM line bases 7'h00/7'h40 in package lcd_resp_pkg.
REQ-031 SHALL implement the busy countdown as sub-module lcd_busy_timer (load, count, done).

Verification
REQ-032 SHALL cover:
  - Reset then 0x38, 0x0C, 0x01, 0x06, 0x80 with spacing > CLEAR_CYC+40 -> disp_on=1, cursor=0, all rd_char=8'h20, cmd_err=0.
  - 0x80 then data 'A'-'P' (RS=1) -> buffer 0-15 = 'A'..'P', cursor=16; 0xC0 then 'Z' -> buffer 16='Z', cursor=17.
  - 0x04 (decrement) then 0x80, data 8'h31 -> buffer 0=8'h31, cursor=31 (wrap).
  - 0x8F then a second write 2 cycles later -> second ignored, cmd_err=1; 0x90 -> cmd_err=1, cursor unchanged.
  - Reset asserted mid-clear at CLR cycle 10 -> busy=0 next cycle, entries 0-9 = 8'h20, rest unchanged.
  - With LCD_RESP_READ_EN, busy-flag read during BUSY after 0x85 -> lcd_dout=8'h85, lcd_dout_oe=1; without the macro -> lcd_dout_oe=0, cmd_err=1.
